// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, FSM states and twiddle generator for the inverse NTT
package ntt_pkg;

  localparam int unsigned NTT_N     = 256;
  localparam int unsigned NTT_Q     = 8380417;
  localparam int unsigned NTT_N_INV = 8347681;
  localparam int unsigned NTT_ROOT  = 1753;

  typedef enum logic [2:0] {
    IDLE, RD, BF, WR, SRD, SMUL, SWR, DONE
  } ntt_state_t;

  // zeta[k] = root^bitrev(k) mod q; evaluated at elaboration to fill the twiddle ROM
  function automatic int unsigned zeta_pow(input int unsigned k, input int unsigned log2n,
                                           input int unsigned root, input int unsigned q);
    longint unsigned acc;
    longint unsigned base;
    longint unsigned m;
    int unsigned     rev;
    acc  = 64'd1;
    m    = 64'(q);
    base = 64'(root) % m;
    rev  = 0;
    for (int unsigned i = 0; i < log2n; i++) rev = (rev << 1) | ((k >> i) & 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (rev[i]) acc = (acc * base) % m;
      base = (base * base) % m;
    end
    return 32'(acc);
  endfunction

endpackage

// File: rtl/coeff_ram.sv
// rtl/coeff_ram.sv - true dual-port coefficient RAM with one-cycle registered reads
module coeff_ram #(
  parameter int unsigned N          = 256,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_wdata_a,
  output logic [WIDTH-1:0]      o_rdata_a,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_wdata_b,
  output logic [WIDTH-1:0]      o_rdata_b
);

  logic [WIDTH-1:0] r_mem [N];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;

  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    r_rdata_a <= r_mem[i_addr_a];
    r_rdata_b <= r_mem[i_addr_b];
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/ntt_inverse_gs_butterfly.sv
// rtl/ntt_inverse_gs_butterfly.sv - combinational Gentleman-Sande butterfly mod Q
module ntt_gs_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned Q     = NTT_Q
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] twiddle,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  localparam logic [WIDTH-1:0]   Q_W  = WIDTH'(Q);
  localparam logic [WIDTH:0]     Q_S  = {1'b0, Q_W};
  localparam logic [2*WIDTH-1:0] Q_P  = {{WIDTH{1'b0}}, Q_W};

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_neg_tw;

  always_comb begin
    w_sum    = {1'b0, a} + {1'b0, b};
    w_diff   = (a >= b) ? (a - b) : (a + (Q_W - b));
    // the inverse uses -zeta; keep zero at zero so the operand stays below Q
    w_neg_tw = (twiddle == '0) ? '0 : (Q_W - twiddle);
    a_out    = (w_sum >= Q_S) ? WIDTH'(w_sum - Q_S) : WIDTH'(w_sum);
    b_out    = WIDTH'(({{WIDTH{1'b0}}, w_diff} * {{WIDTH{1'b0}}, w_neg_tw}) % Q_P);
  end

endmodule

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - bit-reversed power table of the root of unity, registered read
module twiddle_rom
  import ntt_pkg::*;
#(
  parameter int unsigned N          = NTT_N,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned Q          = NTT_Q,
  parameter int unsigned ROOT       = NTT_ROOT
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0]      o_zeta
);

  logic [WIDTH-1:0] w_table [N];
  logic [WIDTH-1:0] r_zeta;

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam logic [WIDTH-1:0] ZETA = WIDTH'(zeta_pow(g, ADDR_WIDTH, ROOT, Q));
    assign w_table[g] = ZETA;
  end

  always_ff @(posedge clk) r_zeta <= w_table[i_addr];

  assign o_zeta = r_zeta;

endmodule

// File: rtl/ntt_inverse.sv
// rtl/ntt_inverse.sv - in-place inverse NTT (Gentleman-Sande) with final N^-1 scaling
module ntt_inverse
  import ntt_pkg::*;
#(
  parameter int unsigned N          = NTT_N,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned Q          = NTT_Q,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned N_INV      = NTT_N_INV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  input  logic                  load_coeff,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  localparam logic [WIDTH-1:0]      Q_W     = WIDTH'(Q);
  localparam logic [WIDTH-1:0]      NINV_W  = WIDTH'(N_INV);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-2:0] ONE_S   = (ADDR_WIDTH-1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ST = ADDR_WIDTH'(ADDR_WIDTH - 1);

  function automatic logic [WIDTH-1:0] mul_ninv(input logic [WIDTH-1:0] x);
    return WIDTH'(({{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, NINV_W}) % {{WIDTH{1'b0}}, Q_W});
  endfunction

  ntt_state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_stage, r_start, r_off, r_k;
  logic [ADDR_WIDTH-2:0] r_sidx;
  logic [WIDTH-1:0]      r_res_a, r_res_b;

  logic [ADDR_WIDTH-1:0] w_len, w_next_start, w_addr_j, w_addr_jl;
  logic                  w_grp_end, w_last_bf, w_last_pair, w_user;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b;
  logic                  w_we_a, w_we_b;
  logic [WIDTH-1:0]      w_wdata_a, w_wdata_b, w_rdata_a, w_rdata_b;
  logic [WIDTH-1:0]      w_zeta, w_bf_a, w_bf_b;

  // a stage's last group is the one whose successor start wraps past N to zero
  assign w_len        = ONE_A << r_stage;
  assign w_next_start = r_start + (w_len << 1);
  assign w_addr_j     = r_start + r_off;
  assign w_addr_jl    = w_addr_j + w_len;
  assign w_grp_end    = (r_off == (w_len - ONE_A));
  assign w_last_bf    = w_grp_end && (w_next_start == '0) && (r_stage == LAST_ST);
  assign w_last_pair  = &r_sidx;
  assign w_user       = (r_state == IDLE) || (r_state == DONE);

  assign busy      = !w_user;
  assign done      = (r_state == DONE);
  assign read_data = w_rdata_b;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RD;
      RD:      w_next = BF;
      BF:      w_next = WR;
      WR:      w_next = w_last_bf ? SRD : RD;
      SRD:     w_next = SMUL;
      SMUL:    w_next = SWR;
      SWR:     w_next = w_last_pair ? DONE : SRD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_addr_a  = w_addr_j;
    w_addr_b  = w_addr_jl;
    w_we_a    = 1'b0;
    w_we_b    = 1'b0;
    w_wdata_a = r_res_a;
    w_wdata_b = r_res_b;
    if (w_user) begin
      w_addr_b  = load_coeff ? load_addr : read_addr;
      w_we_b    = load_coeff;
      w_wdata_b = load_data;
    end else if (r_state inside {SRD, SMUL, SWR}) begin
      w_addr_a = {1'b0, r_sidx};
      w_addr_b = {1'b1, r_sidx};
      w_we_a   = (r_state == SWR);
      w_we_b   = (r_state == SWR);
    end else begin
      w_we_a   = (r_state == WR);
      w_we_b   = (r_state == WR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_start <= '0;
      r_off   <= '0;
      r_k     <= '0;
      r_sidx  <= '0;
      r_res_a <= '0;
      r_res_b <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_stage <= '0;
          r_start <= '0;
          r_off   <= '0;
          r_k     <= ADDR_WIDTH'(N - 1);
          r_sidx  <= '0;
        end
        BF: begin
          r_res_a <= w_bf_a;
          r_res_b <= w_bf_b;
        end
        WR: if (w_grp_end) begin
          r_off <= '0;
          r_k   <= r_k - ONE_A;
          if (w_next_start == '0) begin
            r_start <= '0;
            r_stage <= r_stage + ONE_A;
          end else begin
            r_start <= w_next_start;
          end
        end else begin
          r_off <= r_off + ONE_A;
        end
        SMUL: begin
          r_res_a <= mul_ninv(w_rdata_a);
          r_res_b <= mul_ninv(w_rdata_b);
        end
        SWR: r_sidx <= r_sidx + ONE_S;
        default: ;
      endcase
    end
  end

  coeff_ram #(.N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk       (clk),
    .i_we_a    (w_we_a),
    .i_addr_a  (w_addr_a),
    .i_wdata_a (w_wdata_a),
    .o_rdata_a (w_rdata_a),
    .i_we_b    (w_we_b),
    .i_addr_b  (w_addr_b),
    .i_wdata_b (w_wdata_b),
    .o_rdata_b (w_rdata_b)
  );

  twiddle_rom #(.N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .Q(Q), .ROOT(NTT_ROOT)) u_rom (
    .clk    (clk),
    .i_addr (r_k),
    .o_zeta (w_zeta)
  );

  ntt_gs_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf (
    .a       (w_rdata_a),
    .b       (w_rdata_b),
    .twiddle (w_zeta),
    .a_out   (w_bf_a),
    .b_out   (w_bf_b)
  );

endmodule

// File: tb/tb_ntt_inverse.sv
// tb/tb_ntt_inverse.sv - scoreboard bench: forward-NTT model feeds the DUT, outputs popped and compared
module tb_ntt_inverse;

  localparam longint unsigned QM = 64'd8380417;
  localparam int LAT_EXP    = 3457;
  localparam int LAT_BUDGET = 5000;
  localparam int N_RAND     = 16;

  logic        clk = 1'b0;
  logic        rst, start, done, busy, load_coeff;
  logic [7:0]  load_addr, read_addr;
  logic [31:0] load_data, read_data;

  int n_total = 0;
  int n_bad   = 0;

  longint unsigned zt[256];
  longint unsigned orig[256];
  longint unsigned ntt_in[256];
  longint unsigned exp_out[256];
  longint unsigned sb_q[$];

  always #5 clk = ~clk;

  ntt_inverse dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .load_coeff (load_coeff),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  function automatic longint unsigned powmod(input longint unsigned b, input int e);
    longint unsigned r = 1;
    longint unsigned x = b % QM;
    for (int i = 0; i < e; i++) r = (r * x) % QM;
    return r;
  endfunction

  function automatic void build_zetas();
    for (int k = 0; k < 256; k++) begin
      int rv = 0;
      for (int i = 0; i < 8; i++) rv = (rv << 1) | ((k >> i) & 1);
      zt[k] = powmod(64'd1753, rv);
    end
  endfunction

  // Cooley-Tukey forward transform, natural order in, bit-reversed order out
  function automatic void fwd_ntt();
    int k = 0;
    for (int len = 128; len > 0; len = len >> 1)
      for (int st = 0; st < 256; st = st + 2 * len) begin
        longint unsigned z;
        k++;
        z = zt[k];
        for (int j = st; j < st + len; j++) begin
          longint unsigned t = (z * ntt_in[j + len]) % QM;
          ntt_in[j + len] = (ntt_in[j] + QM - t) % QM;
          ntt_in[j]       = (ntt_in[j] + t) % QM;
        end
      end
  endfunction

  task automatic load_poly();
    for (int i = 0; i < 256; i++) begin
      load_coeff = 1'b1;
      load_addr  = 8'(i);
      load_data  = 32'(ntt_in[i]);
      @(posedge clk); #1;
    end
    load_coeff = 1'b0;
  endtask

  task automatic run_transform(input bit disturb, output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    chk("busy_after_start", busy, 1);
    while (done !== 1'b1 && lat < LAT_BUDGET) begin
      if (disturb) begin
        start      = (lat == 5 || lat == 500);
        load_coeff = (lat == 700);
        load_addr  = 8'd3;
        load_data  = 32'd12345;
      end
      @(posedge clk); #1;
      lat++;
    end
    start      = 1'b0;
    load_coeff = 1'b0;
    chk("busy_at_done", busy, 0);
  endtask

  task automatic read_check(input string tag, input bit range_chk);
    longint unsigned e;
    for (int i = 0; i < 256; i++) begin
      read_addr = 8'(i);
      @(posedge clk); #1;
      if (i == 0) chk("done_one_cycle", done, 0);
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("%s[%0d]", tag, i), read_data, e);
      end
      if (range_chk) chk($sformatf("%s_range[%0d]", tag, i), read_data < 32'(QM), 1);
    end
  endtask

  task automatic run_case(input string tag, input bit disturb, input bit range_chk);
    int lat;
    load_poly();
    for (int i = 0; i < 256; i++) sb_q.push_back(exp_out[i]);
    run_transform(disturb, lat);
    chk({tag, "_latency"}, lat, LAT_EXP);
    read_check(tag, range_chk);
  endtask

  task automatic abort_case();
    int done_seen = 0;
    for (int i = 0; i < 256; i++) ntt_in[i] = $urandom_range(0, 32'(QM) - 1);
    load_poly();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (999) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_coeff = 1'b0;
    load_addr = '0; load_data = '0; read_addr = '0;
    build_zetas();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) begin ntt_in[i] = 0; exp_out[i] = 0; end
    run_case("zeros", 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) begin ntt_in[i] = 1; exp_out[i] = (i == 0) ? 1 : 0; end
    run_case("ones", 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) begin ntt_in[i] = QM - 1; exp_out[i] = (i == 0) ? QM - 1 : 0; end
    run_case("qm1", 1'b0, 1'b1);

    for (int r = 0; r < N_RAND; r++) begin
      if (r == 2) abort_case();
      for (int i = 0; i < 256; i++) begin
        orig[i]    = $urandom_range(0, 32'(QM) - 1);
        ntt_in[i]  = orig[i];
        exp_out[i] = orig[i];
      end
      fwd_ntt();
      run_case($sformatf("rand%0d", r), r == 1, 1'b0);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
